// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage controller and alu_seq.
// The controller drives the request side; the ALU drives the status and result side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             illegal;

    modport master (
        output start, alucontrol, a, b,
        input  busy, done, result, hi, zero, illegal
    );

    modport slave (
        input  start, alucontrol, a, b,
        output busy, done, result, hi, zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU for the execute stage: single-cycle ADD/SUB/AND/OR/SLT and an
// iterative shift-add unsigned MUL that produces a 2*WIDTH product over WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1100;

    logic [0:0]         state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   hi_q;
    logic               nonzero_q;
    logic               done_q;
    logic               illegal_q;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ok;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (bus.alucontrol)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_ok  = 1'b0;
        endcase
    end

    // The multiplicand register is pre-shifted each cycle, so it always holds
    // (multiplicand << count) without a barrel shifter.
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        last_iter = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            nonzero_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    if (bus.alucontrol == OP_MUL) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.a};
                        mplier <= bus.b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL;
                    end else begin
                        result_q  <= alu_res;
                        nonzero_q <= |alu_res;
                        illegal_q <= ~alu_ok;
                        done_q    <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (last_iter) begin
                    result_q  <= acc_next[WIDTH-1:0];
                    hi_q      <= acc_next[2*WIDTH-1:WIDTH];
                    nonzero_q <= |acc_next[WIDTH-1:0];
                    illegal_q <= 1'b0;
                    done_q    <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end

    // Zero is held as an inverted flag so a cleared register reads zero=1 out of reset.
    assign bus.busy    = (state == MUL);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.hi      = hi_q;
    assign bus.zero    = ~nonzero_q;
    assign bus.illegal = illegal_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Execution-side consumer of the 4-bit alucontrol code produced by the ALU decoder.
- Registered ALU with a start/done handshake. Single-cycle ops: ADD, SUB, AND, OR, SLT. Multi-cycle op: iterative unsigned MUL (shift-add) with 2*WIDTH product.
- Sits in the execute stage of the multicycle datapath; the controller holds off the next step until done.

Parameters:
- WIDTH, 32, operand/result width (>= 4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request: sample alucontrol, a, b this edge (accepted only when busy=0)
- alucontrol  input  4  0000 ADD, 0010 SUB, 0100 AND, 0111 OR, 1010 SLT, 1100 MUL; all others illegal
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  1 while a MUL is in progress
- done  output  1  one-cycle pulse: result/hi/zero/illegal updated
- result  output  WIDTH  registered result (low product half for MUL)
- hi  output  WIDTH  high product half; updated only by MUL
- zero  output  1  registered (result == 0), updated with result
- illegal  output  1  1 if the last completed op had an unrecognised code

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy, done, illegal, zero-flag register cleared; result, hi, count, internal accumulators = 0.
  - zero output reads 1 after reset (result=0).
  - Takes effect immediately, including mid-MUL: the operation is aborted, no done pulse.
- States: IDLE, MUL.
- IDLE, start=1, code not MUL (accept edge k):
  - At edge k: result, zero, illegal updated; done=1 for the cycle after edge k; state stays IDLE.
  - Latency 1.
- Single-cycle arithmetic:
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - AND/OR: bitwise.
  - SLT: signed two's-complement compare; result = 1 if a < b, else 0, zero-extended.
- Illegal code: result=0, zero=1, illegal=1, done pulses; hi unchanged.
- Any legal completion clears illegal.
- IDLE, start=1, code=1100 (accept edge k):
  - Load multiplicand=a, multiplier=b, 2*WIDTH accumulator=0, count=0.
  - busy=1, state=MUL.
- In MUL, each edge:
  - If multiplier LSB=1, add (multiplicand << count) to the accumulator.
  - Shift multiplier right by 1; count++.
- At edge k+WIDTH (WIDTH-th iteration):
  - {hi, result} = accumulator; zero = (low half == 0).
  - illegal=0, busy=0, done=1 for one cycle, state=IDLE.
  - Latency WIDTH.
- start while busy=1: ignored entirely, no queueing; the in-flight MUL is unaffected.
- start in the same cycle done=1 (state IDLE): accepted normally, giving back-to-back ops.
- Inputs a, b, alucontrol are don't-care except on the accept edge; changing them mid-MUL has no effect.
- done never asserts for two consecutive cycles for the same op.
- result, hi, zero, illegal hold their values until the next completion.

Test Plan:
- Reset then idle: result=0, hi=0, zero=1, busy=0, done=0, illegal=0. Assert reset mid-MUL at count 10 → all cleared at once, no done pulse.
- Single-cycle ops (WIDTH=32), each followed by a done pulse 1 cycle after start:
  - ADD 0x7FFFFFFF+1 → 0x80000000, zero=0.
  - SUB 5-5 → 0, zero=1.
  - AND 0xF0F0&0x0FF0 → 0x00F0.
  - OR → 0xFFF0.
- SLT signed: a=0xFFFFFFFF (-1), b=1 → result=1; a=1, b=0xFFFFFFFF → 0; a=b → 0.
- MUL:
  - 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, result=0x00000001, done exactly 32 cycles after start, busy high 32 cycles.
  - 0*x → zero=1.
- start pulsed with ADD during busy → ignored; MUL completes with the correct product.
- ADD issued on the done cycle → done again on the next cycle with the ADD result.
- Code 0101 → result=0, illegal=1, done pulses, hi unchanged. The next ADD clears illegal.
